// File: rtl/lsu_pkg.sv
// Shared widths, memory depth and timeout defaults, and the FSM state type for the LSU
// memory master.
package lsu_pkg;

    localparam int unsigned XLEN      = 19;
    localparam int unsigned MEM_DEPTH = 1025;
    localparam int unsigned TIMEOUT   = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Signal bundle between the MEM stage, the LSU and the data memory.
// The master modport is the LSU's view of the bundle; the slave modport is the pipeline and memory side.
interface lsu_mem_master_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            req_ready;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            fault;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, fault,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, fault,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// BUSY-cycle counter for the LSU; expired is high during the TIMEOUT-th cycle after clear drops.
// Instantiated only when LSU_TIMEOUT_EN is defined.
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    assign expired = (cnt_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one access in flight, req/ack memory bus, and a range-check fault.
// Defining LSU_TIMEOUT_EN adds a BUSY timeout that faults an access memory never acks.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = lsu_pkg::MEM_DEPTH
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = lsu_pkg::TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_master_if.master   bus
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic            tmo_expired;
    logic            in_range;

    // Compare at 32 bits so that no address wraps into the legal range.
    assign in_range = (32'(bus.req_addr) < MEM_DEPTH);

`ifdef LSU_TIMEOUT_EN
    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != BUSY),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (in_range) begin
                        we_d    = bus.req_we;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        fault_d = 1'b0;
                        state_d = BUSY;
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                // An ack in the timeout cycle still completes the access normally.
                if (bus.mem_ack) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    fault_d = 1'b0;
                    state_d = RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.fault      = (state_q == RESP) && fault_q;
    assign bus.mem_req    = (state_q == BUSY);
    assign bus.mem_we     = (state_q == BUSY) && we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule
